// File: rtl/sop_eval_pkg.sv
// Shared types and constants for the sum-of-products cover evaluator.
package sop_eval_pkg;

    localparam int SOP_DEF_N_IN   = 17;
    localparam int SOP_DEF_N_CUBE = 8;

    // Evaluator control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One cube-table entry at the default input width.
    typedef struct packed {
        logic                    en;
        logic [SOP_DEF_N_IN-1:0] care;
        logic [SOP_DEF_N_IN-1:0] val;
    } cube_t;

    // Storage bits per cube for a given input width.
    function automatic int cube_bits(input int n_in);
        return 2 * n_in + 1;
    endfunction

endpackage

// File: rtl/sop_cube_match.sv
// Single-cube literal matcher: true when every cared input equals its
// required value and the cube is enabled. An enabled cube with no cared
// literals is the constant-1 cube.
module sop_cube_match #(
    parameter int N_IN = 17
) (
    input  logic [N_IN-1:0] x_i,
    input  logic [N_IN-1:0] care_i,
    input  logic [N_IN-1:0] val_i,
    input  logic            en_i,
    output logic            match_o
);

    assign match_o = en_i && (((x_i ^ val_i) & care_i) == '0);

endmodule

// File: rtl/sop_cover_eval.sv
// Sequential sum-of-products cover evaluator. One cube of a programmable
// flop-based table is tested per cycle; evaluation stops on the first hit.
module sop_cover_eval
    import sop_eval_pkg::*;
#(
    parameter int N_IN   = SOP_DEF_N_IN,
    parameter int N_CUBE = SOP_DEF_N_CUBE,
    parameter int IW     = $clog2(N_CUBE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    output logic            cfg_ready,
    input  logic [IW-1:0]   cfg_addr,
    input  logic [N_IN-1:0] cfg_care,
    input  logic [N_IN-1:0] cfg_val,
    input  logic            cfg_en,
    input  logic            cfg_inv,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_y,
    output logic            out_hit,
    output logic [IW-1:0]   out_idx
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_CUBE - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   oidx_q, oidx_d;
    logic            hit_q, hit_d;
    logic            y_q, y_d;
    logic [N_IN-1:0] x_q;

    logic [N_CUBE-1:0] en_q;
    logic              inv_q;
    logic [N_IN-1:0]   care_q [N_CUBE];
    logic [N_IN-1:0]   val_q  [N_CUBE];

    logic            idle;
    logic            tbl_we;
    logic            accept;
    logic            match;

    assign idle      = (state_q == ST_IDLE);
    assign in_ready  = idle;
    assign cfg_ready = idle;
    assign out_valid = (state_q == ST_DONE);
    assign out_y     = y_q;
    assign out_hit   = hit_q;
    assign out_idx   = oidx_q;

    // Writes outside IDLE are dropped; the writer must wait for cfg_ready.
    assign tbl_we = cfg_we && idle && (int'(cfg_addr) < N_CUBE);
    assign accept = in_valid && idle;

    // Single matcher fed by the table read mux on the current cube index.
    sop_cube_match #(
        .N_IN (N_IN)
    ) u_match (
        .x_i     (x_q),
        .care_i  (care_q[idx_q]),
        .val_i   (val_q[idx_q]),
        .en_i    (en_q[idx_q]),
        .match_o (match)
    );

    // Cube literals and the captured vector are plain data, never reset.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            care_q[cfg_addr] <= cfg_care;
            val_q[cfg_addr]  <= cfg_val;
        end
        if (accept) begin
            x_q <= in_x;
        end
    end

    // Cube enables and output polarity; cleared by reset to the empty cover.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q  <= '0;
            inv_q <= 1'b0;
        end else if (tbl_we) begin
            en_q[cfg_addr] <= cfg_en;
            inv_q          <= cfg_inv;
        end
    end

    // Next-state logic: scan cubes in index order, stop on first hit or last cube.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oidx_d  = oidx_q;
        hit_d   = hit_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    idx_d   = '0;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (match) begin
                    hit_d   = 1'b1;
                    oidx_d  = idx_q;
                    y_d     = ~inv_q;
                    state_d = ST_DONE;
                end else if (idx_q == LAST_IDX) begin
                    hit_d   = 1'b0;
                    oidx_d  = LAST_IDX;
                    y_d     = inv_q;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            oidx_q  <= '0;
            hit_q   <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oidx_q  <= oidx_d;
            hit_q   <= hit_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: tb/tb_sop_cover_eval.sv
// Bench for sop_cover_eval: directed vector table, multi-cycle corner
// sequences, and randomized vectors against a cover-level reference model.
module tb_sop_cover_eval;

  localparam int N_IN   = 17;
  localparam int N_CUBE = 8;
  localparam int IW     = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic            cfg_ready;
  logic [IW-1:0]   cfg_addr;
  logic [N_IN-1:0] cfg_care;
  logic [N_IN-1:0] cfg_val;
  logic            cfg_en;
  logic            cfg_inv;
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_x;
  logic            out_valid;
  logic            out_ready;
  logic            out_y;
  logic            out_hit;
  logic [IW-1:0]   out_idx;

  always #5 clk = ~clk;

  sop_cover_eval #(
    .N_IN   (N_IN),
    .N_CUBE (N_CUBE),
    .IW     (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_care  (cfg_care),
    .cfg_val   (cfg_val),
    .cfg_en    (cfg_en),
    .cfg_inv   (cfg_inv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_hit   (out_hit),
    .out_idx   (out_idx)
  );

  int checks = 0;
  int passes = 0;

  // reference model of the programmed cover
  logic            m_en   [N_CUBE];
  logic [N_IN-1:0] m_care [N_CUBE];
  logic [N_IN-1:0] m_val  [N_CUBE];
  logic            m_inv;

  typedef struct {
    string           nm;
    logic [N_IN-1:0] x;
    logic            hit;
    int              idx;
    logic            y;
    int              lat;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_CUBE; i++) m_en[i] = 1'b0;
    m_inv = 1'b0;
  endtask

  // first matching cube found by scanning from the top down and keeping the lowest
  task automatic model_eval(input logic [N_IN-1:0] x, output logic hit, output int idx,
                            output logic y, output int lat);
    hit = 1'b0;
    idx = N_CUBE - 1;
    for (int i = N_CUBE - 1; i >= 0; i--)
      if (m_en[i] && (((x ^ m_val[i]) & m_care[i]) == '0)) begin
        hit = 1'b1;
        idx = i;
      end
    y   = hit ^ m_inv;
    lat = hit ? idx + 1 : N_CUBE;
  endtask

  task automatic cfg_write(input int addr, input logic [N_IN-1:0] care, input logic [N_IN-1:0] val,
                           input logic en, input logic inv);
    int n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) chk("cfg_ready_timeout", 0, 1);
    cfg_we = 1'b1; cfg_addr = IW'(addr); cfg_care = care; cfg_val = val;
    cfg_en = en; cfg_inv = inv;
    @(posedge clk);
    m_en[addr] = en; m_care[addr] = care; m_val[addr] = val; m_inv = inv;
    #1 cfg_we = 1'b0;
  endtask

  // Presents a vector (optionally with a concurrent table write); returns 1 time unit after acceptance edge.
  task automatic start_vec(input logic [N_IN-1:0] x, input logic wr, input int addr,
                           input logic [N_IN-1:0] care, input logic [N_IN-1:0] val,
                           input logic en, input logic inv);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_x     = x;
    if (wr) begin
      cfg_we = 1'b1; cfg_addr = IW'(addr); cfg_care = care; cfg_val = val;
      cfg_en = en; cfg_inv = inv;
    end
    @(posedge clk);
    if (wr) begin
      m_en[addr] = en; m_care[addr] = care; m_val[addr] = val; m_inv = inv;
    end
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    in_x     = N_IN'($urandom);
  endtask

  task automatic wait_check(input string nm, input logic eh, input int eidx, input logic ey,
                            input int elat);
    int lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 64);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_y"}, out_y, ey);
    chk({nm, "_hit"}, out_hit, eh);
    chk({nm, "_idx"}, out_idx, eidx);
  endtask

  task automatic handshake(input string nm, input int dly);
    repeat (dly) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({nm, "_idle_after"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic run_vec(input string nm, input logic [N_IN-1:0] x, input logic eh,
                         input int eidx, input logic ey, input int elat);
    start_vec(x, 1'b0, 0, '0, '0, 1'b0, 1'b0);
    wait_check(nm, eh, eidx, ey, elat);
    handshake(nm, 0);
  endtask

  initial begin
    logic            mh, my;
    int              mi, ml, seen, j;
    logic [N_IN-1:0] x;

    tbl[0] = '{"c3_hit",    17'h0004A, 1'b1, 3, 1'b1, 4};
    tbl[1] = '{"c3_x4",     17'h0005A, 1'b0, 7, 1'b0, 8};
    tbl[2] = '{"c3_x16",    17'h1004A, 1'b0, 7, 1'b0, 8};
    tbl[3] = '{"c3_dc_lo",  17'h0004F, 1'b1, 3, 1'b1, 4};
    tbl[4] = '{"c3_dc_mid", 17'h02FEA, 1'b1, 3, 1'b1, 4};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_care = '0; cfg_val = '0;
    cfg_en = 1'b0; cfg_inv = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {out_valid, out_y, out_hit, out_idx}, 0);
    chk("rst_readies", {in_ready, cfg_ready}, 2'b11);
    @(negedge clk) rst = 1'b0;

    // empty cover, then POS polarity
    run_vec("empty", 17'h00000, 1'b0, 7, 1'b0, 8);
    cfg_write(0, '0, '0, 1'b0, 1'b1);
    run_vec("empty_inv", 17'h00000, 1'b0, 7, 1'b1, 8);

    // cube 3 directed table
    cfg_write(3, 17'h1D05A, 17'h0004A, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      run_vec(tbl[i].nm, tbl[i].x, tbl[i].hit, tbl[i].idx, tbl[i].y, tbl[i].lat);

    // lowest index wins and terminates early
    cfg_write(5, '0, '0, 1'b1, 1'b0);
    cfg_write(0, 17'h00001, 17'h00001, 1'b1, 1'b0);
    run_vec("early_c0", 17'h0004B, 1'b1, 0, 1'b1, 1);
    run_vec("c3_before_c5", 17'h0004A, 1'b1, 3, 1'b1, 4);

    // result held while the consumer stalls and the source toggles
    start_vec(17'h0004B, 1'b0, 0, '0, '0, 1'b0, 1'b0);
    wait_check("hold", 1'b1, 0, 1'b1, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      in_x     = N_IN'($urandom);
      @(posedge clk);
      #1;
      chk("hold_stable", {in_ready, out_valid, out_y, out_hit, out_idx}, {1'b0, 1'b1, 1'b1, 1'b1, 3'd0});
    end
    in_valid = 1'b0;
    handshake("hold", 0);

    // write during EVAL is dropped
    start_vec(17'h0004A, 1'b0, 0, '0, '0, 1'b0, 1'b0);
    chk("cfg_ready_eval", cfg_ready, 0);
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_care = '0; cfg_val = '0; cfg_en = 1'b0; cfg_inv = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    wait_check("drop", 1'b1, 3, 1'b1, 3);   // one evaluation edge already elapsed
    handshake("drop", 1);

    // write concurrent with acceptance is used for this vector
    start_vec(17'h0004A, 1'b1, 3, 17'h1D05A, 17'h0004A, 1'b0, 1'b0);
    wait_check("concurrent", 1'b1, 5, 1'b1, 6);
    handshake("concurrent", 0);

    // reset while evaluating cube 2
    start_vec(17'h0004A, 1'b0, 0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    model_clear();
    chk("midrst_outputs", {out_valid, out_y, out_hit, out_idx}, 0);
    chk("midrst_readies", {in_ready, cfg_ready}, 2'b11);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    run_vec("post_rst", 17'h0004A, 1'b0, 7, 1'b0, 8);

    // randomized tables and vectors against the model
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < N_CUBE; c++)
        cfg_write(c, N_IN'($urandom & $urandom & $urandom), N_IN'($urandom),
                  1'(($urandom % 4) != 0), 1'($urandom));
      for (int v = 0; v < 15; v++) begin
        if ($urandom % 2) begin
          j = int'($urandom % N_CUBE);
          x = m_val[j] ^ (N_IN'($urandom) & ~m_care[j]);
        end else begin
          x = N_IN'($urandom);
        end
        start_vec(x, 1'b0, 0, '0, '0, 1'b0, 1'b0);
        model_eval(x, mh, mi, my, ml);
        wait_check("rand", mh, mi, my, ml);
        handshake("rand", int'($urandom % 4));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sop_cover_eval.md
# sop_cover_eval

Sequential, parametrised evaluator for a single-output sum-of-products cover over `N_IN` primary inputs. It supersedes the fixed, flattened combinational projection netlists with a programmable cube table. It tests one cube per cycle and terminates early on the first hit. It sits between the benchmark vector source and the result checker, using valid/ready handshakes on both sides.

## Interface
Parameters:
- `N_IN`, 17: number of primary inputs, x0 is bit 0.
- `N_CUBE`, 8: cube table depth, ≥2.
- `IW`, `$clog2(N_CUBE)`: cube index width, derived.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: cube-table write strobe.
- `cfg_ready` out 1: table writable; high only in IDLE.
- `cfg_addr` in IW: cube slot.
- `cfg_care` in N_IN: 1 means the literal is present in the cube.
- `cfg_val` in N_IN: required value of each cared input.
- `cfg_en` in 1: slot enable written with the cube.
- `cfg_inv` in 1: output polarity. When 1, y is the complement of the cover (POS mode). Sampled at every cfg write.
- `in_valid` in 1, `in_ready` out 1, `in_x` in N_IN: input-vector handshake.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_y` out 1: function value.
- `out_hit` out 1: a cube matched.
- `out_idx` out IW: index of the first matching cube, or N_CUBE-1 on a miss.

## Operation
- Cube i matches x iff `cube_en[i] && ((x ^ val[i]) & care[i]) == 0`. A cube with all-zero care and en=1 is the constant-1 cube.
- FSM states are IDLE, EVAL and DONE.
  - IDLE: in_ready=1, cfg_ready=1. On in_valid, capture in_x, set idx=0, go to EVAL.
  - EVAL: test cube[idx].
    - On a match, set hit=1, out_idx=idx, go to DONE.
    - Else if idx==N_CUBE-1, set hit=0, out_idx=N_CUBE-1, go to DONE.
    - Else idx++.
  - DONE: out_valid=1, y=hit^inv. Outputs are held stable until out_ready, then the FSM goes to IDLE.
- Table writes take effect only when cfg_we && cfg_ready. A cfg_we outside IDLE is dropped (no queueing); the writer must wait for cfg_ready.
- A simultaneous cfg write and input acceptance in IDLE is legal. The write lands in the same edge, so the new cube is used for this vector.
- The captured vector is immune to in_x changes after acceptance.

## Timing
- Acceptance is edge E0 (in_valid && in_ready). For a hit on cube k, out_valid rises after edge E0+k+1. On a miss it rises after E0+N_CUBE. Worst-case latency is N_CUBE cycles.
- out_valid && out_ready at edge Ed → IDLE after Ed. The next vector is accepted at Ed+1 at the earliest. Throughput is at most one vector per latency+2 cycles.
- Reset values:
  - state=IDLE, in_ready=1, cfg_ready=1.
  - out_valid=0, out_y=0, out_hit=0, out_idx=0.
  - all cube_en=0, inv=0; the empty cover gives y=0.
  - care/val are not reset.
- Reset mid-EVAL or mid-DONE aborts immediately. The result is lost and no out_valid pulse appears.
- No combinational path from in_valid or out_ready to any output except through registered state.

## Structure
- Package `sop_eval_pkg` holds:
  - `state_t` enum (IDLE, EVAL, DONE);
  - `cube_t` struct {en, care[N_IN], val[N_IN]}, parametrised via package function or localparam default N_IN=17;
  - constant `SOP_DEF_N_CUBE`.
- Sub-module `sop_cube_match`: combinational, with inputs x, care, val, en and output match. It is instantiated once and fed from a table read mux on idx.
- Table is flop-based; N_CUBE × (2·N_IN+1) bits.

## Test plan
- Reset, then x=17'h00000 with an empty table → out_valid after 8 cycles, y=0, hit=0, idx=7. Repeat with inv=1 → y=1.
- Cube3 with care=x1,x3,x4,x6,x12,x14,x15,x16 and val x1=x3=x6=1, others 0; x=17'h0004A → hit on cube 3, idx=3, y=1, out_valid 4 cycles after acceptance. Flip x4 to 1 → miss, y=0, latency 8.
- Cube0 and cube5 both match the same x → idx=0, latency 1, which confirms early termination on the lowest index.
- Hold out_ready=0 for 10 cycles in DONE while in_x and in_valid toggle → outputs stable, in_ready=0, no second acceptance.
- Drive cfg_we during EVAL targeting the matching cube with en=0 → write dropped, original hit reported. Then write in IDLE concurrently with acceptance → new contents used.
- Assert rst at EVAL idx=2 → no out_valid, all outputs at reset values, table enables cleared. The next vector gives y=inv=0.
